// File: rtl/jk_seq_counter_pkg.sv
// Shared types and helpers for the JK sequence counter.
// The mode encoding matches the 2-bit mode port of jk_seq_counter.
package jk_seq_counter_pkg;

  // Helpers run at a fixed wide width. Callers zero-extend their W-bit value
  // and truncate the result.
  localparam int JK_MAX_W = 32;

  typedef logic [JK_MAX_W-1:0] word_t;

  typedef enum logic [1:0] {
    BIN_UP  = 2'd0,
    BIN_DN  = 2'd1,
    GRAY_UP = 2'd2,
    JOHNSON = 2'd3
  } mode_e;

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of the Gray bits at and above it.
  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b = g;
    for (int i = 1; i < JK_MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  // A legal Johnson state over the low w bits has at most one 0/1 boundary,
  // e.g. 0011 or 1100. Patterns such as 0101 are not reachable by shifting.
  function automatic logic johnson_valid(input word_t v, input int w);
    int edges;
    edges = 0;
    for (int i = 0; i < JK_MAX_W - 1; i++) begin
      if ((i < w - 1) && (v[i] != v[i+1])) edges++;
    end
    return (edges <= 1);
  endfunction

endpackage

// File: rtl/jk_seq_counter_jk_cell.sv
// Single JK flip-flop with synchronous active-high reset.
// Truth table: 00 hold, 01 clear, 10 set, 11 toggle. qb is always ~q.
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  // State update: reset first, then the JK truth table.
  // NOTE: sequential state is written with non-blocking assignments so every
  // cell samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      unique case ({j, k})
        2'b00: q <= q;
        2'b01: q <= 1'b0;
        2'b10: q <= 1'b1;
        2'b11: q <= ~q;
      endcase
    end
  end

  assign qb = ~q;

endmodule

// File: rtl/jk_seq_counter.sv
// Multi-mode synchronous counter built from W JK cells.
// Modes: binary up, binary down, Gray up, Johnson; synchronous load,
// saturate-or-wrap, terminal-count flag and a registered wrap pulse.
// Optional feature: define JKCNT_SKIP_EN to add skip_val, which makes the
// binary modes step over one chosen value.
module jk_seq_counter
  import jk_seq_counter_pkg::*;
#(
  parameter int W       = 4,
  parameter int MAX_VAL = (2**W) - 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [1:0]   mode,
  input  logic         sat,
`ifdef JKCNT_SKIP_EN
  input  logic [W-1:0] skip_val,
`endif
  output logic [W-1:0] q,
  output logic [W-1:0] qb,
  output logic         tc,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_Q = W'(MAX_VAL);
  // bin2gray(2**W-1) and the last Johnson state are both {1,0..0}.
  localparam logic [W-1:0] TOP_BIT = {1'b1, {(W-1){1'b0}}};

  mode_e        cur_mode;
  logic [W-1:0] term;
  logic [W-1:0] q_next;
  logic [W-1:0] gray_bin_inc;
  logic [W-1:0] j_v;
  logic [W-1:0] k_v;
  logic         held;
  logic         wrap_set;
  logic         wrap_q;
  logic         wrap_qb;

  // Out-of-range values (only reachable by load) restart at 0.
  // The compare is one bit wider so it stays meaningful when MAX_VAL = 2**W-1.
  function automatic logic [W-1:0] step_up(input logic [W-1:0] v, input logic s);
    if ({1'b0, v} > {1'b0, MAX_Q}) return '0;
    if (v == MAX_Q)                return s ? v : '0;
    return v + W'(1);
  endfunction

  // Out-of-range values (only reachable by load) restart at MAX_VAL.
  function automatic logic [W-1:0] step_dn(input logic [W-1:0] v, input logic s);
    if ({1'b0, v} > {1'b0, MAX_Q}) return MAX_Q;
    if (v == '0)                   return s ? v : MAX_Q;
    return v - W'(1);
  endfunction

  assign cur_mode = mode_e'(mode);

  // Terminal state of the mode currently selected; q is reinterpreted on a mode change.
  always_comb begin
    term = '0;
    unique case (cur_mode)
      BIN_UP:  term = MAX_Q;
      BIN_DN:  term = '0;
      GRAY_UP: term = TOP_BIT;
      JOHNSON: term = TOP_BIT;
    endcase
  end

  assign tc   = (q == term);
  assign held = sat & tc;

  // Truncate to W bits before re-encoding so the Gray sequence wraps mod 2**W.
  assign gray_bin_inc = W'(gray2bin(word_t'(q)) + word_t'(1));

  // Value q takes on an enabled edge.
  // NOTE: every variable written in a combinational block gets a default first,
  // otherwise an uncovered path infers a latch.
  always_comb begin
    q_next = q;
    unique case (cur_mode)
      BIN_UP: begin
        q_next = step_up(q, sat);
`ifdef JKCNT_SKIP_EN
        if (!held && (q_next == skip_val)) q_next = step_up(q_next, sat);
`endif
      end
      BIN_DN: begin
        q_next = step_dn(q, sat);
`ifdef JKCNT_SKIP_EN
        if (!held && (q_next == skip_val)) q_next = step_dn(q_next, sat);
`endif
      end
      GRAY_UP: begin
        q_next = held ? q : W'(bin2gray(word_t'(gray_bin_inc)));
      end
      JOHNSON: begin
        if (!johnson_valid(word_t'(q), W)) q_next = '0;
        else if (held)                     q_next = q;
        else                               q_next = {q[W-2:0], ~q[W-1]};
      end
    endcase
  end

  // JK excitation per bit: reset clears, load forces d, count toggles changed bits.
  always_comb begin
    j_v = '0;
    k_v = '0;
    if (reset) begin
      j_v = '0;
      k_v = '1;
    end else if (load) begin
      j_v = load_val;
      k_v = ~load_val;
    end else if (en) begin
      j_v = q ^ q_next;
      k_v = q ^ q_next;
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j_v[i]),
      .k     (k_v[i]),
      .q     (q[i]),
      .qb    (qb[i])
    );
  end

  // Wrap pulse: set only when currently clear, clear only when currently set.
  assign wrap_set = ~reset & ~load & en & tc & ~sat;

  jk_cell u_wrap (
    .clk   (clk),
    .reset (reset),
    .j     (wrap_set & wrap_qb),
    .k     (~wrap_set & wrap_q),
    .q     (wrap_q),
    .qb    (wrap_qb)
  );

  assign wrap = wrap_q;

endmodule
